imu_spi_responder: RTL and testbench

//  SPI slave that emulates the IMU end of the jb_imu link: accepts a command byte, then streams a

---
 rtl/imu_spi_responder.sv | 205 ++++++++++++++++++++
 tb/tb_imu_spi_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imu_spi_responder.sv
// imu_spi_responder
//   SPI mode-0 slave emulating the IMU end of the jb_imu link. The master sends a
//   command byte, and the slave returns a status byte while that byte is shifted in.
//   If the command is CMD_READ, the slave then streams a snapshot of NUM_WORDS
//   16-bit sensor words, MSB first. The snapshot is taken when the command byte
//   completes. sck/ss/mosi are asynchronous and are oversampled by clock.
// Ports
//   clock        system clock, at least 8x the sck frequency
//   reset        asynchronous, active-high reset
//   sck, ss, mosi  SPI pins from the master (ss is active low)
//   miso         slave-out data, changes on sck fall
//   sensor_data  packed words; word k at [16k+15:16k]
//   cmd_valid    1-cycle pulse when the command byte completes
//   cmd_byte     last received command byte
//   frame_done   1-cycle pulse after the last data bit of a read frame
//   frame_abort  1-cycle pulse when ss deasserts during CMD or DATA
//   busy         synchronised ss asserted
//   state_dbg    current FSM state (IDLE=0 CMD=1 DATA=2 IGNORE=3 DRAIN=4)
module imu_spi_responder #(
  parameter int         NUM_WORDS = 9,
  parameter logic [7:0] CMD_READ  = 8'hA5,
  parameter logic [7:0] STATUS    = 8'h5A,
  parameter logic [7:0] FILL      = 8'h00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sck,
  input  logic                     ss,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [16*NUM_WORDS-1:0]  sensor_data,
  output logic                     cmd_valid,
  output logic [7:0]               cmd_byte,
  output logic                     frame_done,
  output logic                     frame_abort,
  output logic                     busy,
  output logic [2:0]               state_dbg
);

  localparam int NUM_BYTES = 2 * NUM_WORDS;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DATA   = 3'd2,
    IGNORE = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  // Pin synchronisers: bits [1:0] form the two-flop synchroniser, and bit [2] is the
  // delayed copy used for edge detection.
  logic [2:0] sck_sr_q, ss_sr_q;
  logic [1:0] mosi_sr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sr_q  <= 3'b000;
      ss_sr_q   <= 3'b111;
      mosi_sr_q <= 2'b00;
    end else begin
      sck_sr_q  <= {sck_sr_q[1:0], sck};
      ss_sr_q   <= {ss_sr_q[1:0], ss};
      mosi_sr_q <= {mosi_sr_q[0], mosi};
    end
  end

  logic ss_s, ss_fall, ss_rise, sck_rise, sck_fall, mosi_s;
  logic sck_rise_en, sck_fall_en;

  assign ss_s     = ss_sr_q[1];
  assign ss_fall  = ss_sr_q[2] & ~ss_sr_q[1];
  assign ss_rise  = ~ss_sr_q[2] & ss_sr_q[1];
  assign sck_rise = sck_sr_q[1] & ~sck_sr_q[2];
  assign sck_fall = ~sck_sr_q[1] & sck_sr_q[2];
  assign mosi_s   = mosi_sr_q[1];

  // A rise that lands in the same cycle as the ss rise is still processed. This lets
  // a frame whose last bit coincides with deselect complete, instead of aborting.
  assign sck_rise_en = sck_rise & (~ss_s | ss_rise);
  assign sck_fall_en = sck_fall & ~ss_s;

  state_e                   state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [6:0]               rx_q, rx_d;
  logic [7:0]               tx_q, tx_d;
  logic [7:0]               cmd_byte_q, cmd_byte_d;
  logic [16*NUM_WORDS-1:0]  frame_q, frame_d;
  logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_abort_q, frame_abort_d;

  logic [7:0] rx_byte;
  logic [7:0] next_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_q          <= 7'd0;
      tx_q          <= 8'd0;
      cmd_byte_q    <= 8'd0;
      frame_q       <= '0;
      byte_idx_q    <= '0;
      cmd_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      cmd_byte_q    <= cmd_byte_d;
      frame_q       <= frame_d;
      byte_idx_q    <= byte_idx_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    cmd_byte_d    = cmd_byte_q;
    frame_d       = frame_q;
    byte_idx_d    = byte_idx_q;
    cmd_valid_d   = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    rx_byte       = {rx_q, mosi_s};
    next_byte     = FILL;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = CMD;
          tx_d      = STATUS;
          bit_cnt_d = 3'd0;
        end
      end
      default: begin
        if (sck_rise_en) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              cmd_byte_d  = rx_byte;
              cmd_valid_d = 1'b1;
              if (rx_byte == CMD_READ) begin
                frame_d    = sensor_data;
                byte_idx_d = '0;
                state_d    = DATA;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == DATA) begin
              if (byte_idx_q == LAST_IDX) begin
                frame_done_d = 1'b1;
                state_d      = DRAIN;
              end else begin
                byte_idx_d = byte_idx_q + IDX_ONE;
              end
            end
          end
        end else if (sck_fall_en) begin
          if (bit_cnt_q == 3'd0) begin
            // The low 16 bits of frame_q always hold the current word. The register
            // shifts down by one word once that word's low byte has been loaded.
            if (state_q == DATA) begin
              next_byte = byte_idx_q[0] ? frame_q[7:0] : frame_q[15:8];
              if (byte_idx_q[0]) frame_d = frame_q >> 16;
            end
            tx_d = next_byte;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end

        if (ss_rise) begin
          state_d       = IDLE;
          tx_d          = 8'd0;
          bit_cnt_d     = 3'd0;
          frame_abort_d = ((state_q == CMD) || (state_q == DATA)) && !frame_done_d;
        end
      end
    endcase
  end

  // miso is the tx register MSB. The register is cleared in IDLE, so miso stays low
  // while the slave is deselected.
  assign miso        = tx_q[7];
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign busy        = ~ss_s;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_imu_spi_responder.sv
// Testbench for imu_spi_responder: drives SPI mode-0 transfers and checks the miso
// bytes against an expected queue built from the bench's own sensor-word model.
module tb_imu_spi_responder;

  localparam int         NW       = 9;
  localparam int         HALF     = 5;   // sck half period in clock cycles
  localparam logic [7:0] CMD_READ = 8'hA5;
  localparam logic [7:0] STATUS   = 8'h5A;
  localparam logic [7:0] FILL     = 8'h00;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            sck   = 1'b0;
  logic            ss    = 1'b1;
  logic            mosi  = 1'b0;
  logic            miso;
  logic [16*NW-1:0] sensor_data = '0;
  logic            cmd_valid;
  logic [7:0]      cmd_byte;
  logic            frame_done;
  logic            frame_abort;
  logic            busy;
  logic [2:0]      state_dbg;

  // clock / reset
  always #5 clock = ~clock;

  imu_spi_responder dut (
    .clock       (clock),
    .reset       (reset),
    .sck         (sck),
    .ss          (ss),
    .mosi        (mosi),
    .miso        (miso),
    .sensor_data (sensor_data),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  int n_cv  = 0;
  int n_fd  = 0;
  int n_fa  = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] words[NW];

  // pulse counters
  always @(negedge clock) begin
    if (cmd_valid)   n_cv++;
    if (frame_done)  n_fd++;
    if (frame_abort) n_fa++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_words(input bit rnd);
    for (int k = 0; k < NW; k++) begin
      words[k] = rnd ? 16'($urandom_range(0, 65535)) : {8'(k + 1), 8'(k)};
      sensor_data[16*k +: 16] = words[k];
    end
  endtask

  function automatic logic [7:0] frame_byte(input int j);
    logic [15:0] w;
    w = words[j / 2];
    return j[0] ? w[7:0] : w[15:8];
  endfunction

  // driver: MSB-first transfer of nbits; miso is sampled just before each sck rise
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit ss_last,
                          output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clock);
      rx[i] = miso;
      sck = 1'b1;
      if (ss_last && (i == 8 - nbits)) ss = 1'b1;
      repeat (HALF) @(negedge clock);
      sck = 1'b0;
    end
  endtask

  // One select period: nbytes transfers, with last_bits bits in the final one.
  task automatic run_frame(input logic [7:0] cmd, input int nbytes, input int last_bits,
                           input bit ss_last, input bit corrupt, input string tag);
    logic [7:0] rx, exp, mask;
    int full_data, nb;
    bit exp_fd;
    n_cv = 0; n_fd = 0; n_fa = 0;
    exp_q.delete();
    exp_q.push_back(STATUS);
    for (int j = 0; j < nbytes - 1; j++)
      exp_q.push_back((cmd == CMD_READ && j < 2*NW) ? frame_byte(j) : FILL);
    full_data = nbytes - 1 - ((last_bits < 8) ? 1 : 0);
    exp_fd    = (cmd == CMD_READ) && (full_data >= 2*NW);

    ss = 1'b0;
    repeat (6) @(negedge clock);
    check({tag, ":busy_sel"}, busy, 1);
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : 8;
      spi_xfer((b == 0) ? cmd : 8'($urandom_range(0, 255)), nb, ss_last && (b == nbytes - 1), rx);
      exp  = exp_q.pop_front();
      mask = 8'hFF << (8 - nb);
      check($sformatf("%s:miso[%0d]", tag, b), rx & mask, exp & mask);
      if (b == 0 && corrupt) sensor_data = '1;
      if (cmd == CMD_READ && nb == 8 && b == 2*NW - 1) check({tag, ":fd_early"}, n_fd, 0);
      if (cmd == CMD_READ && nb == 8 && b == 2*NW)     check({tag, ":fd_last"}, n_fd, 1);
    end
    if (!ss_last) begin
      repeat (HALF) @(negedge clock);
      ss = 1'b1;
    end
    repeat (8) @(negedge clock);
    check({tag, ":cmd_valid_n"}, n_cv, 1);
    check({tag, ":cmd_byte"}, cmd_byte, cmd);
    check({tag, ":frame_done_n"}, n_fd, exp_fd);
    check({tag, ":frame_abort_n"}, n_fa, (cmd == CMD_READ) && !exp_fd);
    check({tag, ":miso_idle"}, miso, 0);
    check({tag, ":busy_idle"}, busy, 0);
    check({tag, ":state_idle"}, state_dbg, 0);
  endtask

  initial begin
    logic [7:0] rx;

    // 1: reset values, then sck activity while deselected
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst:miso", miso, 0);
    check("rst:busy", busy, 0);
    check("rst:cmd_byte", cmd_byte, 0);
    check("rst:pulses", {cmd_valid, frame_done, frame_abort}, 0);
    check("rst:state", state_dbg, 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sck = ~sck;
      repeat (HALF) @(negedge clock);
    end
    check("desel:miso", miso, 0);
    check("desel:busy", busy, 0);
    check("desel:pulses", n_cv + n_fd + n_fa, 0);
    check("desel:state", state_dbg, 0);

    // 2: full read frame with counting words
    load_words(1'b0);
    run_frame(CMD_READ, 19, 8, 1'b0, 1'b0, "t2");

    // 3: sensor data overwritten after the command byte; one drain byte after the frame
    load_words(1'b0);
    run_frame(CMD_READ, 20, 8, 1'b0, 1'b1, "t3");

    // 4: non-read command
    load_words(1'b1);
    run_frame(8'h3C, 4, 8, 1'b0, 1'b0, "t4");

    // 5: abort after 5 data bytes and 3 bits, then a full frame
    load_words(1'b1);
    run_frame(CMD_READ, 7, 3, 1'b0, 1'b0, "t5a");
    load_words(1'b1);
    run_frame(CMD_READ, 19, 8, 1'b0, 1'b0, "t5b");

    // 6: reset during DATA, then a fresh frame
    load_words(1'b1);
    n_cv = 0; n_fd = 0; n_fa = 0;
    ss = 1'b0;
    repeat (6) @(negedge clock);
    spi_xfer(CMD_READ, 8, 1'b0, rx);
    check("t6:status", rx, STATUS);
    for (int j = 0; j < 3; j++) begin
      spi_xfer(8'($urandom_range(0, 255)), 8, 1'b0, rx);
      check($sformatf("t6:data[%0d]", j), rx, frame_byte(j));
    end
    reset = 1'b1;
    #1;
    check("t6:rst_miso", miso, 0);
    check("t6:rst_cmd_byte", cmd_byte, 0);
    check("t6:rst_busy", busy, 0);
    check("t6:rst_pulses", {cmd_valid, frame_done, frame_abort}, 0);
    check("t6:rst_state", state_dbg, 0);
    ss = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    n_cv = 0; n_fd = 0; n_fa = 0;
    repeat (10) @(negedge clock);
    check("t6:post_rst_pulses", n_cv + n_fd + n_fa, 0);
    load_words(1'b1);
    run_frame(CMD_READ, 19, 8, 1'b0, 1'b0, "t6b");

    // 7: last data bit and deselect arrive together
    load_words(1'b1);
    run_frame(CMD_READ, 19, 8, 1'b1, 1'b0, "t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
